// File: rtl/uart_tx_parity4_pkg.sv
// rtl/uart_tx_parity4_pkg.sv - shared types and constants for the parity UART transmitter
//
// Contents:
//   state_t    FSM state encoding (GUARD, IDLE, START, DATA, PARITY, STOP)
//   DATA_BITS  payload bits per frame
//   FRAME_BASE frame cycles excluding stop bits (start + data + parity)
//   PAYLOAD_W  width of one buffered entry ({perr, data})
//   frame_len  total frame cycles for a given stop-bit count
package uart_tx_parity4_pkg;

  typedef enum logic [2:0] {
    ST_GUARD,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int DATA_BITS  = 4;
  localparam int FRAME_BASE = 1 + DATA_BITS + 1;
  localparam int PAYLOAD_W  = DATA_BITS + 1;

  function automatic int frame_len(input int stop_bits);
    return FRAME_BASE + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_parity4_if.sv
// rtl/uart_tx_parity4_if.sv - nibble handshake between a producer and the transmitter
//
// Signals:
//   data_in   nibble to transmit
//   valid_in  data_in/perr_in valid this cycle
//   perr_in   invert the parity bit of this nibble
//   ready_out transmitter accepts data this cycle
// Modports: master (producer), slave (transmitter)
interface uart_tx_parity4_if;
  import uart_tx_parity4_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 valid_in;
  logic                 perr_in;
  logic                 ready_out;

  modport master (output data_in, output valid_in, output perr_in, input ready_out);
  modport slave  (input data_in, input valid_in, input perr_in, output ready_out);

endinterface

// File: rtl/uart_tx_holdreg.sv
// rtl/uart_tx_holdreg.sv - one-entry valid/ready holding register
//
// Ports:
//   clk, reset          clock, synchronous active-high reset (empties the entry)
//   in_valid/in_ready   write side handshake, in_data payload
//   out_valid/out_ready read side handshake, out_data payload
// in_ready is simply "empty", so a write and a read never coincide.
module uart_tx_holdreg
  import uart_tx_parity4_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  logic                 full_q;
  logic [PAYLOAD_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid && !full_q) begin
      full_q <= 1'b1;
      data_q <= in_data;
    end else if (full_q && out_ready) begin
      full_q <= 1'b0;
    end
  end

  assign in_ready  = !full_q;
  assign out_valid = full_q;
  assign out_data  = data_q;

endmodule

// File: rtl/uart_tx_parity4.sv
// rtl/uart_tx_parity4.sv - 4-bit serial transmitter with parity and a one-entry buffer
//
// Parameters:
//   STOP_BITS    stop-bit cycles per frame (1 or 2)
//   GUARD_CYCLES line-high cycles after reset before any frame (1..15)
// Ports:
//   clk   clock
//   reset synchronous, active-high
//   up    nibble handshake (slave side)
//   tx    registered serial line, idle high
//   busy  frame in progress or nibble buffered
// Frame: start(0), d0..d3 LSB first, parity (^data ^ perr), STOP_BITS x 1.
module uart_tx_parity4
  import uart_tx_parity4_pkg::*;
#(
  parameter int STOP_BITS    = 1,
  parameter int GUARD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_parity4_if.slave   up,
  output logic               tx,
  output logic               busy
);

  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);
  localparam logic       STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic [1:0] BIT_LAST   = 2'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic [1:0]           bitcnt_q, bitcnt_d;
  logic                 stopcnt_q, stopcnt_d;
  logic [3:0]           guardcnt_q, guardcnt_d;
  logic                 tx_d;

  logic                 hold_in_valid, hold_in_ready;
  logic                 hold_out_valid, hold_pop;
  logic [PAYLOAD_W-1:0] hold_out_data;
  logic                 parity;

  // Nothing is taken in during GUARD so the first frame always follows a full guard period.
  assign hold_in_valid = up.valid_in && (state_q != ST_GUARD);
  assign up.ready_out  = hold_in_ready && (state_q != ST_GUARD);

  uart_tx_holdreg u_hold (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (hold_in_valid),
    .in_ready  (hold_in_ready),
    .in_data   ({up.perr_in, up.data_in}),
    .out_valid (hold_out_valid),
    .out_ready (hold_pop),
    .out_data  (hold_out_data)
  );

  assign parity = (^data_q) ^ perr_q;

  // tx is registered from the value of the state being entered, so the line
  // always matches state_q in the same cycle.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    perr_d     = perr_q;
    bitcnt_d   = bitcnt_q;
    stopcnt_d  = stopcnt_q;
    guardcnt_d = guardcnt_q;
    tx_d       = 1'b1;
    hold_pop   = 1'b0;

    unique case (state_q)
      ST_GUARD: begin
        if (guardcnt_q == GUARD_LAST) begin
          state_d    = ST_IDLE;
          guardcnt_d = '0;
        end else begin
          guardcnt_d = guardcnt_q + 4'd1;
        end
      end
      ST_IDLE: begin
        if (hold_out_valid) begin
          state_d  = ST_START;
          data_d   = hold_out_data[DATA_BITS-1:0];
          perr_d   = hold_out_data[DATA_BITS];
          hold_pop = 1'b1;
          tx_d     = 1'b0;
        end
      end
      ST_START: begin
        state_d  = ST_DATA;
        bitcnt_d = '0;
        tx_d     = data_q[0];
      end
      ST_DATA: begin
        if (bitcnt_q == BIT_LAST) begin
          state_d = ST_PARITY;
          tx_d    = parity;
        end else begin
          bitcnt_d = bitcnt_q + 2'd1;
          tx_d     = data_q[bitcnt_q + 2'd1];
        end
      end
      ST_PARITY: begin
        state_d   = ST_STOP;
        stopcnt_d = 1'b0;
      end
      ST_STOP: begin
        if (stopcnt_q == STOP_LAST) begin
          // A waiting nibble starts immediately: no idle gap between frames.
          if (hold_out_valid) begin
            state_d  = ST_START;
            data_d   = hold_out_data[DATA_BITS-1:0];
            perr_d   = hold_out_data[DATA_BITS];
            hold_pop = 1'b1;
            tx_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          stopcnt_d = stopcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_GUARD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_GUARD;
      data_q     <= '0;
      perr_q     <= 1'b0;
      bitcnt_q   <= '0;
      stopcnt_q  <= 1'b0;
      guardcnt_q <= '0;
      tx         <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      bitcnt_q   <= bitcnt_d;
      stopcnt_q  <= stopcnt_d;
      guardcnt_q <= guardcnt_d;
      tx         <= tx_d;
    end
  end

  assign busy = hold_out_valid || ((state_q != ST_IDLE) && (state_q != ST_GUARD));

endmodule

// File: tb/tb_uart_tx_parity4.sv
// tb/tb_uart_tx_parity4.sv - directed self-checking bench for uart_tx_parity4
module tb_uart_tx_parity4;

  logic clk = 1'b0;
  logic reset;
  logic tx1, busy1, tx2, busy2;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  uart_tx_parity4_if if1 ();
  uart_tx_parity4_if if2 ();

  uart_tx_parity4 #(.STOP_BITS(1), .GUARD_CYCLES(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .up    (if1),
    .tx    (tx1),
    .busy  (busy1)
  );

  uart_tx_parity4 #(.STOP_BITS(2), .GUARD_CYCLES(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .up    (if2),
    .tx    (tx2),
    .busy  (busy2)
  );

  // bits: expected tx sequence from the start bit, first bit in bits[7]
  typedef struct {
    int         sel;
    logic [3:0] data;
    logic       perr;
    int         nbits;
    logic [7:0] bits;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [3:0] d, input logic p);
    if (sel == 0) begin
      if1.valid_in = v; if1.data_in = d; if1.perr_in = p;
    end else begin
      if2.valid_in = v; if2.data_in = d; if2.perr_in = p;
    end
  endtask

  function automatic logic get_tx(input int sel);
    return (sel == 0) ? tx1 : tx2;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy1 : busy2;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? if1.ready_out : if2.ready_out;
  endfunction

  // Entered and left on a negedge; all sampling happens on negedges.
  task automatic run_frame(input vec_t v);
    for (int k = 0; k < 40; k++) begin
      if (get_ready(v.sel)) break;
      @(negedge clk);
    end
    chk("ready_wait", 8'(get_ready(v.sel)), 8'd1);
    drive(v.sel, 1'b1, v.data, v.perr);
    @(posedge clk);
    @(negedge clk);
    drive(v.sel, 1'b0, 4'd0, 1'b0);
    chk("pre_start_tx", 8'(get_tx(v.sel)), 8'd1);
    chk("pre_start_busy", 8'(get_busy(v.sel)), 8'd1);
    for (int i = 0; i < v.nbits; i++) begin
      @(negedge clk);
      chk($sformatf("frame_bit%0d_d%0h", i, v.data), 8'(get_tx(v.sel)), 8'(v.bits[7-i]));
      if (i == 3) chk("frame_busy", 8'(get_busy(v.sel)), 8'd1);
    end
    @(negedge clk);
    chk("post_tx", 8'(get_tx(v.sel)), 8'd1);
    chk("post_busy", 8'(get_busy(v.sel)), 8'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [13:0] exp14;
    logic        seen0;

    vecs[0] = '{0, 4'b1011, 1'b0, 7, 8'b0110_1111};
    vecs[1] = '{0, 4'b0000, 1'b1, 7, 8'b0000_0111};
    vecs[2] = '{0, 4'b0110, 1'b0, 7, 8'b0011_0011};
    vecs[3] = '{0, 4'b1111, 1'b0, 7, 8'b0111_1011};
    vecs[4] = '{0, 4'b0001, 1'b1, 7, 8'b0100_0011};
    vecs[5] = '{1, 4'b1111, 1'b0, 8, 8'b0111_1011};
    vecs[6] = '{1, 4'b0110, 1'b1, 8, 8'b0011_0111};

    reset = 1'b1;
    drive(0, 1'b0, 4'd0, 1'b0);
    drive(1, 1'b0, 4'd0, 1'b0);

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_tx", 8'(tx1), 8'd1);
      chk("reset_ready", 8'(if1.ready_out), 8'd0);
      chk("reset_busy", 8'(busy1), 8'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("guard_tx", 8'(tx1), 8'd1);
    chk("guard_ready", 8'(if1.ready_out), 8'd0);
    @(negedge clk);
    chk("guard_tx2", 8'(tx1), 8'd1);
    chk("idle_ready", 8'(if1.ready_out), 8'd1);
    chk("idle_ready_dut2", 8'(if2.ready_out), 8'd1);

    for (int n = 0; n < 7; n++) run_frame(vecs[n]);

    // Back-to-back frames with valid held: 1011 then 0110.
    exp14 = {7'b0110111, 7'b0011001};
    drive(0, 1'b1, 4'b1011, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 4'b0110, 1'b0);
    chk("b2b_ready_full", 8'(if1.ready_out), 8'd0);
    chk("b2b_pre_tx", 8'(tx1), 8'd1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) chk("b2b_ready_free", 8'(if1.ready_out), 8'd1);
      if (i == 1) begin
        chk("b2b_ready_held", 8'(if1.ready_out), 8'd0);
        drive(0, 1'b0, 4'd0, 1'b0);
      end
      if (i == 7) chk("b2b_busy", 8'(busy1), 8'd1);
      chk($sformatf("b2b_bit%0d", i), 8'(tx1), 8'(exp14[13-i]));
    end
    @(negedge clk);
    chk("b2b_post_tx", 8'(tx1), 8'd1);
    chk("b2b_post_busy", 8'(busy1), 8'd0);

    // Reset during DATA with the buffer full.
    drive(0, 1'b1, 4'b0011, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 4'b0101, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 1'b0);
    chk("rst_mid_d0", 8'(tx1), 8'd1);
    chk("rst_mid_busy", 8'(busy1), 8'd1);
    @(negedge clk);
    chk("rst_mid_d1", 8'(tx1), 8'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", 8'(tx1), 8'd1);
    chk("rst_mid_busy0", 8'(busy1), 8'd0);
    chk("rst_mid_ready0", 8'(if1.ready_out), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_guard_ready", 8'(if1.ready_out), 8'd0);
    @(negedge clk);
    chk("rst_idle_ready", 8'(if1.ready_out), 8'd1);
    seen0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx1 !== 1'b1 || busy1 !== 1'b0) seen0 = 1'b1;
      @(negedge clk);
    end
    chk("rst_no_start", 8'(seen0), 8'd0);
    run_frame(vecs[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
